// File: rtl/mxv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mxv_pkg : shared constants, FSM state codes and batch helpers for    |
// |           the matrix-by-vector batch scheduler.                      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mxv_pkg;

   localparam int CNT_W = 32;
   localparam int ST_W  = 3;

   localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [ST_W-1:0] ST_FETCH    = 3'd1;
   localparam logic [ST_W-1:0] ST_WAIT_RDY = 3'd2;
   localparam logic [ST_W-1:0] ST_LAUNCH   = 3'd3;
   localparam logic [ST_W-1:0] ST_COLLECT  = 3'd4;
   localparam logic [ST_W-1:0] ST_DRAIN    = 3'd5;
   localparam logic [ST_W-1:0] ST_DONE     = 3'd6;

   // One extra bit so the rounding add cannot wrap for very large jobs.
   function automatic logic [CNT_W:0] batch_count(input logic [CNT_W-1:0] rows,
                                                  input int lanes_log2);
      logic [CNT_W:0] sum;
      sum = {1'b0, rows} + (((CNT_W+1)'(1) << lanes_log2) - (CNT_W+1)'(1));
      return sum >> lanes_log2;
   endfunction

   function automatic logic [4:0] batch_rem(input logic [4:0] rows_lsb,
                                            input int lanes_log2);
      return rows_lsb & ((5'd1 << lanes_log2) - 5'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mxv_batch_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mxv_batch_scheduler_if : job, operand-fetch, lane and result         |
// |                          handshakes of the batch scheduler.          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface mxv_batch_scheduler_if #(
   parameter int LANES = 4
);
   logic                      start;
   logic [mxv_pkg::CNT_W-1:0] total_rows;
   logic                      mem_rd_req;
   logic [mxv_pkg::CNT_W-1:0] mem_rd_batch;
   logic                      mem_rd_valid;
   logic [LANES-1:0]          lane_ready;
   logic [LANES-1:0]          lane_start;
   logic [LANES-1:0]          lane_done;
   logic                      res_valid;
   logic                      res_accept;
   logic [LANES-1:0]          res_mask;
   logic                      busy;
   logic                      finish;

   modport master (
      input  start, total_rows, mem_rd_valid, lane_ready, lane_done, res_accept,
      output mem_rd_req, mem_rd_batch, lane_start, res_valid, res_mask, busy, finish
   );

   modport slave (
      output start, total_rows, mem_rd_valid, lane_ready, lane_done, res_accept,
      input  mem_rd_req, mem_rd_batch, lane_start, res_valid, res_mask, busy, finish
   );
endinterface
`default_nettype wire

// File: rtl/mxv_done_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mxv_done_collector : sticky per-lane done accumulator with mask.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mxv_done_collector #(
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [LANES-1:0] mask,
   input  logic [LANES-1:0] lane_done,
   output logic             all_done
);
   logic [LANES-1:0] r_sticky;

   always_ff @(posedge clk) begin
      if (reset || clear)
         r_sticky <= '0;
      else if (enable)
         r_sticky <= r_sticky | (lane_done & mask);
   end

   // The pulse that completes the set counts in the same cycle.
   assign all_done = &(r_sticky | (lane_done & mask) | ~mask);
endmodule
`default_nettype wire

// File: rtl/mxv_batch_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mxv_batch_scheduler : fetch / launch / collect / drain sequencer for |
// |                       the matrix-by-vector lanes, one batch at once. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mxv_batch_scheduler
   import mxv_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int LANES_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   mxv_batch_scheduler_if.master bus
);
   logic [ST_W-1:0]  r_state;
   logic [CNT_W-1:0] r_batch;
   logic [CNT_W:0]   r_nb;
   logic [4:0]       r_rem;
   logic [LANES-1:0] r_mask;
   logic             r_req;

   logic [CNT_W:0]   w_nb_in;
   logic [4:0]       w_rem_in;
   logic [CNT_W-1:0] w_batch_inc;
   logic             w_is_last;
   logic             w_busy;
   logic             w_all_done;
   logic             w_clear;

   function automatic logic [LANES-1:0] lane_mask(input logic [CNT_W:0]   nb,
                                                  input logic [CNT_W-1:0] batch,
                                                  input logic [4:0]       rem);
      logic [LANES-1:0] m;
      m = '1;
      if ((({1'b0, batch} + (CNT_W+1)'(1)) == nb) && (rem != 5'd0))
         m = m >> (LANES - int'(rem));
      return m;
   endfunction

   assign w_nb_in     = batch_count(bus.total_rows, LANES_LOG2);
   assign w_rem_in    = batch_rem(bus.total_rows[4:0], LANES_LOG2);
   assign w_batch_inc = r_batch + CNT_W'(1);
   assign w_is_last   = ({1'b0, r_batch} + (CNT_W+1)'(1)) == r_nb;
   assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign w_clear     = (r_state == ST_LAUNCH) || !w_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_batch <= '0;
         r_nb    <= '0;
         r_rem   <= '0;
         r_mask  <= '0;
         r_req   <= 1'b0;
      end else if ((r_state != ST_IDLE) && !bus.start) begin
         // Abort, and also the normal DONE -> IDLE exit.
         r_state <= ST_IDLE;
         r_batch <= '0;
         r_mask  <= '0;
         r_req   <= 1'b0;
      end else begin
         r_req <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_nb    <= w_nb_in;
                  r_rem   <= w_rem_in;
                  r_batch <= '0;
                  if (bus.total_rows == '0) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_FETCH;
                     r_req   <= 1'b1;
                     r_mask  <= lane_mask(w_nb_in, '0, w_rem_in);
                  end
               end
            end
            ST_FETCH: begin
               if (bus.mem_rd_valid)
                  r_state <= ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
               if (&(bus.lane_ready | ~r_mask))
                  r_state <= ST_LAUNCH;
            end
            ST_LAUNCH: begin
               r_state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (w_all_done)
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (bus.res_accept) begin
                  r_batch <= w_batch_inc;
                  if (w_is_last) begin
                     r_state <= ST_DONE;
                     r_mask  <= '0;
                  end else begin
                     r_state <= ST_FETCH;
                     r_req   <= 1'b1;
                     r_mask  <= lane_mask(r_nb, w_batch_inc, r_rem);
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   mxv_done_collector #(
      .LANES (LANES)
   ) u_collector (
      .clk       (clk),
      .reset     (reset),
      .clear     (w_clear),
      .enable    (r_state == ST_COLLECT),
      .mask      (r_mask),
      .lane_done (bus.lane_done),
      .all_done  (w_all_done)
   );

   assign bus.mem_rd_req   = r_req;
   assign bus.mem_rd_batch = (r_state == ST_FETCH) ? r_batch : '0;
   assign bus.lane_start   = (r_state == ST_LAUNCH) ? r_mask : '0;
   assign bus.res_valid    = (r_state == ST_DRAIN);
   assign bus.res_mask     = r_mask;
   assign bus.busy         = w_busy;
   assign bus.finish       = (r_state == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_mxv_batch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mxv_batch_scheduler : vector table plus memory/lane/decoder       |
// |                          models with a scoreboard.                   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_mxv_batch_scheduler;
   import mxv_pkg::*;

   localparam int LANES = 4;

   typedef struct {
      int rows;
      int fetch_lat;
      int rdy_hold;
      int acc_delay;
      int dly [LANES];
      bit stray;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mxv_batch_scheduler_if #(.LANES(LANES)) bus ();

   mxv_batch_scheduler #(
      .LANES      (LANES),
      .LANES_LOG2 (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   int               exp_batch_q [$];
   logic [LANES-1:0] exp_start_q [$];
   logic [LANES-1:0] exp_res_q   [$];

   int fetch_lat = 0, rdy_hold = 0, acc_delay = 0;
   int dly [LANES];
   bit stray_en = 1'b0;

   bit               fetch_wait = 1'b0, pending = 1'b0;
   int               fetch_cnt = 0, hold_cnt = 0, acc_cnt = 0;
   logic [CNT_W-1:0] fetch_batch = '0;
   int               done_cnt [LANES];
   int               launch_cyc = 0, valid_cyc = 0, maxd = 0;
   int               n_req = 0, n_launch = 0, n_xfer = 0;
   logic [LANES-1:0] rdy_v;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory, lane and decoder models; they also pop and compare the scoreboard.
   initial begin : env
      forever begin
         tick();
         cyc++;
         bus.mem_rd_valid = 1'b0;
         bus.lane_done    = '0;
         bus.res_accept   = 1'b0;

         if (bus.mem_rd_req) begin
            n_req++;
            check("req_while_result_pending", pending, 0);
            check("req_expected", exp_batch_q.size() != 0, 1);
            if (exp_batch_q.size() != 0)
               check("mem_rd_batch", bus.mem_rd_batch, exp_batch_q.pop_front());
            fetch_wait  = 1'b1;
            fetch_batch = bus.mem_rd_batch;
            fetch_cnt   = fetch_lat;
         end else if (fetch_wait) begin
            check("mem_rd_batch_stable", bus.mem_rd_batch, fetch_batch);
         end
         if (fetch_wait) begin
            if (fetch_cnt == 0) begin
               bus.mem_rd_valid = 1'b1;
               fetch_wait       = 1'b0;
               valid_cyc        = cyc;
               hold_cnt         = rdy_hold + 1;
            end else begin
               fetch_cnt--;
            end
         end

         for (int i = 0; i < LANES; i++) begin
            if (done_cnt[i] > 0) begin
               done_cnt[i]--;
               if (done_cnt[i] == 0)
                  bus.lane_done[i] = 1'b1;
            end
         end
         if (bus.lane_start != '0) begin
            n_launch++;
            launch_cyc = cyc;
            maxd       = 0;
            check("launch_after_ready", cyc - valid_cyc, rdy_hold + 2);
            check("lane_start_expected", exp_start_q.size() != 0, 1);
            if (exp_start_q.size() != 0)
               check("lane_start", bus.lane_start, exp_start_q.pop_front());
            for (int i = 0; i < LANES; i++) begin
               if (bus.lane_start[i]) begin
                  done_cnt[i] = dly[i];
                  if (dly[i] > maxd)
                     maxd = dly[i];
               end else if (stray_en) begin
                  done_cnt[i] = 1;
               end
            end
         end

         if (bus.res_valid) begin
            if (!pending) begin
               pending = 1'b1;
               acc_cnt = acc_delay;
               check("drain_latency", cyc - launch_cyc, maxd + 1);
            end
            if (acc_cnt == 0) begin
               bus.res_accept = 1'b1;
               pending        = 1'b0;
               n_xfer++;
               check("res_expected", exp_res_q.size() != 0, 1);
               if (exp_res_q.size() != 0)
                  check("res_mask", bus.res_mask, exp_res_q.pop_front());
            end else begin
               acc_cnt--;
            end
         end else if (pending) begin
            check("res_valid_held", bus.res_valid, 1);
            pending = 1'b0;
         end

         for (int i = 0; i < LANES; i++)
            rdy_v[i] = (hold_cnt == 0) && (done_cnt[i] == 0);
         bus.lane_ready = rdy_v;
         if (hold_cnt > 0)
            hold_cnt--;
      end
   end

   task automatic flush_sb();
      exp_batch_q.delete();
      exp_start_q.delete();
      exp_res_q.delete();
   endtask

   task automatic run_job(input vec_t v);
      int nb, rem, k;
      logic [LANES-1:0] m;
      nb  = (v.rows + LANES - 1) / LANES;
      rem = v.rows % LANES;
      for (int b = 0; b < nb; b++) begin
         m = (b == nb - 1 && rem != 0) ? (4'hF >> (LANES - rem)) : 4'hF;
         exp_batch_q.push_back(b);
         exp_start_q.push_back(m);
         exp_res_q.push_back(m);
      end
      fetch_lat = v.fetch_lat;
      rdy_hold  = v.rdy_hold;
      acc_delay = v.acc_delay;
      dly       = v.dly;
      stray_en  = v.stray;
      n_req = 0; n_launch = 0; n_xfer = 0;
      bus.total_rows = v.rows;
      bus.start      = 1'b1;
      k = 0;
      while (bus.finish !== 1'b1 && k < 2000) begin
         tick();
         k++;
      end
      check("finish", bus.finish, 1);
      check("busy_at_finish", bus.busy, 0);
      check("fetch_count", n_req, nb);
      check("launch_count", n_launch, nb);
      check("transfer_count", n_xfer, nb);
      check("scoreboard_left", exp_batch_q.size() + exp_start_q.size() + exp_res_q.size(), 0);
      tick();
      check("finish_held", bus.finish, 1);
      bus.start = 1'b0;
      tick();
      check("finish_cleared", bus.finish, 0);
      check("busy_cleared", bus.busy, 0);
      flush_sb();
   endtask

   task automatic check_quiet(input string pfx);
      check({pfx, "_mem_rd_req"}, bus.mem_rd_req, 0);
      check({pfx, "_mem_rd_batch"}, bus.mem_rd_batch, 0);
      check({pfx, "_lane_start"}, bus.lane_start, 0);
      check({pfx, "_res_valid"}, bus.res_valid, 0);
      check({pfx, "_res_mask"}, bus.res_mask, 0);
      check({pfx, "_busy"}, bus.busy, 0);
      check({pfx, "_finish"}, bus.finish, 0);
   endtask

   task automatic abort_run(input bit use_reset);
      int k;
      bit noisy;
      vec_t again;
      exp_batch_q.push_back(0);
      exp_start_q.push_back(4'hF);
      fetch_lat = 0; rdy_hold = 0; acc_delay = 0; stray_en = 1'b0;
      dly = '{20, 20, 20, 20};
      n_launch = 0;
      bus.total_rows = 8;
      bus.start      = 1'b1;
      k = 0;
      while (n_launch == 0 && k < 100) begin
         tick();
         k++;
      end
      check("abort_launched", n_launch, 1);
      tick();
      tick();
      check("abort_busy_in_collect", bus.busy, 1);
      if (use_reset)
         reset = 1'b1;
      else
         bus.start = 1'b0;
      tick();
      check_quiet(use_reset ? "reset_abort" : "start_abort");
      bus.start = 1'b0;
      reset     = 1'b0;
      noisy     = 1'b0;
      repeat (30) begin
         tick();
         if (bus.busy || bus.res_valid || bus.finish || bus.mem_rd_req || (bus.lane_start != '0))
            noisy = 1'b1;
      end
      check("abort_quiet_after", noisy, 0);
      flush_sb();
      again = '{4, 1, 0, 0, '{2, 3, 4, 5}, 1'b0};
      run_job(again);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
      $fatal(1);
   end

   initial begin : main
      vecs[0] = '{8,  1, 0, 0,  '{5, 5, 5, 5}, 1'b0};
      vecs[1] = '{6,  0, 1, 1,  '{5, 5, 5, 5}, 1'b1};
      vecs[2] = '{4,  2, 0, 0,  '{4, 8, 1, 8}, 1'b0};
      vecs[3] = '{5,  0, 3, 10, '{2, 3, 1, 2}, 1'b1};
      vecs[4] = '{1,  3, 0, 2,  '{1, 1, 1, 1}, 1'b0};
      vecs[5] = '{13, 0, 2, 0,  '{3, 1, 2, 1}, 1'b1};

      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.total_rows   = '0;
      bus.mem_rd_valid = 1'b0;
      bus.lane_ready   = '0;
      bus.lane_done    = '0;
      bus.res_accept   = 1'b0;
      repeat (3) tick();
      check_quiet("reset");
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++)
         run_job(vecs[i]);

      // Empty job goes straight to DONE.
      n_req = 0; n_launch = 0;
      bus.total_rows = 0;
      bus.start      = 1'b1;
      tick();
      tick();
      check("zero_rows_finish", bus.finish, 1);
      check("zero_rows_busy", bus.busy, 0);
      check("zero_rows_no_fetch", n_req, 0);
      check("zero_rows_no_launch", n_launch, 0);
      bus.start = 1'b0;
      tick();
      check("zero_rows_finish_cleared", bus.finish, 0);

      abort_run(1'b0);
      abort_run(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
